// File: rtl/fir_cfg_pkg.sv
// fir_cfg_pkg: shared constants, state enum and preset kernels
// for the FIR coefficient sequencer (presets used under FIR_PRESET_EN).
package fir_cfg_pkg;

    localparam int NUM_TAPS     = 25;
    localparam int COEFF_W      = 16;
    localparam int ADDR_STRIDE  = 4;
    localparam int IDENTITY_IDX = 12;
    localparam int UNITY        = 256;
    localparam int KDIM         = 5;

    localparam int BOX_COEFF    = 10;
    localparam int SHARP_CENTRE = 2304;
    localparam int SHARP_RING   = -256;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_SEND   = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_t;

    // 1-4-6-4-1 binomial row; its outer product sums to 256
    function automatic int gauss_w(input int k);
        int w;
        w = 4;
        if (k == 0 || k == 4) w = 1;
        else if (k == 2) w = 6;
        return w;
    endfunction

    function automatic logic signed [COEFF_W-1:0] preset_coeff(
        input logic [1:0] sel,
        input int         i
    );
        int r;
        int c;
        int v;
        r = i / KDIM;
        c = i % KDIM;
        v = 0;
        unique case (sel)
            2'd0: v = (i == IDENTITY_IDX) ? UNITY : 0;
            2'd1: v = BOX_COEFF;
            2'd2: begin
                if (r == 2 && c == 2)
                    v = SHARP_CENTRE;
                else if (r >= 1 && r <= 3 && c >= 1 && c <= 3)
                    v = SHARP_RING;
            end
            default: v = gauss_w(r) * gauss_w(c);
        endcase
        return COEFF_W'(v);
    endfunction

endpackage

// File: rtl/fir_coeff_presets.sv
// fir_coeff_presets: combinational preset kernel ROM,
// instantiated by the sequencer only when FIR_PRESET_EN is defined.
module fir_coeff_presets
    import fir_cfg_pkg::*;
(
    input  logic [1:0]                         sel,
    output logic [NUM_TAPS-1:0][COEFF_W-1:0]   coeffs
);

    // expand the selected kernel into all taps
    always_comb begin
        for (int i = 0; i < NUM_TAPS; i++) begin
            coeffs[i] = preset_coeff(sel, i);
        end
    end

endmodule

// File: rtl/fir_coeff_sequencer.sv
// fir_coeff_sequencer: shadow kernel store, vsync-aligned upload over
// split addr/data valid-ready channels. FIR_PRESET_EN adds preset loads.
module fir_coeff_sequencer
    import fir_cfg_pkg::seq_state_t,
           fir_cfg_pkg::ST_IDLE,
           fir_cfg_pkg::ST_ARMED,
           fir_cfg_pkg::ST_SEND,
           fir_cfg_pkg::ST_FINISH,
           fir_cfg_pkg::IDENTITY_IDX,
           fir_cfg_pkg::UNITY;
#(
    parameter int COEFF_W     = fir_cfg_pkg::COEFF_W,
    parameter int NUM_TAPS    = fir_cfg_pkg::NUM_TAPS,
    parameter int ADDR_STRIDE = fir_cfg_pkg::ADDR_STRIDE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_wr,
    input  logic [4:0]         cfg_idx,
    input  logic [COEFF_W-1:0] cfg_coeff,
    input  logic               cfg_commit,
    input  logic               cfg_abort,
    input  logic               err_clr,
`ifdef FIR_PRESET_EN
    input  logic               cfg_preset_load,
    input  logic [1:0]         cfg_preset_sel,
`endif
    input  logic               vs_i,
    output logic [31:0]        filter_addr,
    output logic               filter_addr_valid,
    input  logic               filter_addr_ready,
    output logic [31:0]        filter_data,
    output logic               filter_data_valid,
    input  logic               filter_data_ready,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef logic signed [COEFF_W-1:0] coeff_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_TAPS - 1);

    coeff_t      shadow [NUM_TAPS];
    seq_state_t  state;
    seq_state_t  state_d;
    logic [4:0]  idx;
    logic [4:0]  idx_d;
    logic [4:0]  nxt;
    logic        av;
    logic        av_d;
    logic        dv;
    logic        dv_d;
    logic [31:0] addr_q;
    logic [31:0] addr_d;
    logic [31:0] data_q;
    logic [31:0] data_d;
    logic        err_q;
    logic        err_d;
    logic        vs_q;
    logic        vs_rise;
    logic        in_idle;
    logic        idx_ok;
    logic        a_hs;
    logic        d_hs;
    logic        preset_hit;
    logic        wr_ok;
    logic        err_set;

`ifdef FIR_PRESET_EN
    logic [NUM_TAPS-1:0][COEFF_W-1:0] preset_k;

    fir_coeff_presets u_presets (
        .sel    (cfg_preset_sel),
        .coeffs (preset_k)
    );

    assign preset_hit = cfg_preset_load;
`else
    assign preset_hit = 1'b0;
`endif

    function automatic logic [31:0] sext(input coeff_t c);
        return {{(32-COEFF_W){c[COEFF_W-1]}}, c};
    endfunction

    function automatic logic [31:0] addr_of(input logic [4:0] i);
        return 32'(i) * 32'(ADDR_STRIDE);
    endfunction

    assign in_idle = (state == ST_IDLE);
    assign idx_ok  = int'(cfg_idx) < NUM_TAPS;
    assign vs_rise = vs_i & ~vs_q;
    assign a_hs    = av & filter_addr_ready;
    assign d_hs    = dv & filter_data_ready;
    assign nxt     = idx + 5'd1;
    assign wr_ok   = in_idle & cfg_wr & idx_ok & ~preset_hit;
    assign err_set = (cfg_wr & (~in_idle | ~idx_ok))
                   | (cfg_commit & ~in_idle)
                   | (preset_hit & ~in_idle);

    // host-side shadow kernel; preset load beats a same-cycle write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                shadow[i] <= (i == IDENTITY_IDX) ? COEFF_W'(UNITY) : '0;
            end
`ifdef FIR_PRESET_EN
        end else if (preset_hit && in_idle) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                shadow[i] <= preset_k[i];
            end
`endif
        end else if (wr_ok) begin
            shadow[cfg_idx] <= cfg_coeff;
        end
    end

    // state, channel trackers, payload and sticky status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            av     <= 1'b0;
            dv     <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            vs_q   <= 1'b0;
        end else begin
            state  <= state_d;
            idx    <= idx_d;
            av     <= av_d;
            dv     <= dv_d;
            addr_q <= addr_d;
            data_q <= data_d;
            err_q  <= err_d;
            vs_q   <= vs_i;
        end
    end

    // next state; a channel whose valid is low has finished the entry
    always_comb begin
        state_d = state;
        idx_d   = idx;
        av_d    = av;
        dv_d    = dv;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state)
            ST_IDLE: begin
                if (cfg_commit) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (cfg_abort) begin
                    state_d = ST_IDLE;
                end else if (vs_rise) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                    av_d    = 1'b1;
                    dv_d    = 1'b1;
                    addr_d  = addr_of(5'd0);
                    data_d  = sext(shadow[0]);
                end
            end
            ST_SEND: begin
                av_d = av & ~a_hs;
                dv_d = dv & ~d_hs;
                if (!av_d && !dv_d) begin
                    if (idx == LAST_IDX) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d  = nxt;
                        av_d   = 1'b1;
                        dv_d   = 1'b1;
                        addr_d = addr_of(nxt);
                        data_d = sext(shadow[nxt]);
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // sticky error: a set event beats a same-cycle clear
    always_comb begin
        err_d = err_q;
        if (err_set)      err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
    end

    assign filter_addr       = addr_q;
    assign filter_addr_valid = av;
    assign filter_data       = data_q;
    assign filter_data_valid = dv;
    assign busy              = (state != ST_IDLE);
    assign done              = (state == ST_FINISH);
    assign err               = err_q;

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// tb_fir_coeff_sequencer: directed + randomized bench with a kernel
// model; define FIR_PRESET_EN to also exercise preset loads.
module tb_fir_coeff_sequencer;

    logic        clk;
    logic        rst;
    logic        cfg_wr;
    logic [4:0]  cfg_idx;
    logic [15:0] cfg_coeff;
    logic        cfg_commit;
    logic        cfg_abort;
    logic        err_clr;
`ifdef FIR_PRESET_EN
    logic        cfg_preset_load;
    logic [1:0]  cfg_preset_sel;
`endif
    logic        vs_i;
    logic [31:0] filter_addr;
    logic        filter_addr_valid;
    logic        filter_addr_ready;
    logic [31:0] filter_data;
    logic        filter_data_valid;
    logic        filter_data_ready;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int shadow_m [25];
    bit err_m;
    int dc;

    fir_coeff_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_wr            (cfg_wr),
        .cfg_idx           (cfg_idx),
        .cfg_coeff         (cfg_coeff),
        .cfg_commit        (cfg_commit),
        .cfg_abort         (cfg_abort),
        .err_clr           (err_clr),
`ifdef FIR_PRESET_EN
        .cfg_preset_load   (cfg_preset_load),
        .cfg_preset_sel    (cfg_preset_sel),
`endif
        .vs_i              (vs_i),
        .filter_addr       (filter_addr),
        .filter_addr_valid (filter_addr_valid),
        .filter_addr_ready (filter_addr_ready),
        .filter_data       (filter_data),
        .filter_data_valid (filter_data_valid),
        .filter_data_ready (filter_data_ready),
        .busy              (busy),
        .done              (done),
        .err               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 25; i++) shadow_m[i] = 0;
        shadow_m[12] = 256;
        err_m = 1'b0;
    endtask

    task automatic wr(input int i, input int v);
        cfg_wr    = 1'b1;
        cfg_idx   = 5'(i);
        cfg_coeff = 16'(v);
        tick();
        cfg_wr = 1'b0;
        if (i < 25) shadow_m[i] = v;
        else err_m = 1'b1;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    // mode 0: readies high, 1: data stalls 3 cycles per entry, 2: random
    task automatic upload(input int mode, input bit inject, output int done_cyc);
        int e;
        int cyc;
        int dst;
        bit a_dn;
        bit d_dn;
        bit fin;
        done_cyc = -1;
        e = 0; cyc = 0; dst = 0;
        a_dn = 0; d_dn = 0; fin = 0;
        vs_i = 1'b1;
        tick();
        while (!fin && cyc < 1000) begin
            if (e == 25) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("valids_after_last",
                    {30'd0, filter_addr_valid, filter_data_valid}, 32'd0);
                done_cyc = cyc;
                fin = 1;
            end else begin
                chk("addr_valid", 32'(filter_addr_valid), 32'(!a_dn));
                chk("data_valid", 32'(filter_data_valid), 32'(!d_dn));
                if (!a_dn) chk("addr", filter_addr, 32'(e * 4));
                if (!d_dn) chk("data", filter_data, 32'(shadow_m[e]));
                chk("done_low", 32'(done), 32'd0);
                case (mode)
                    0: begin
                        filter_addr_ready = 1'b1;
                        filter_data_ready = 1'b1;
                    end
                    1: begin
                        filter_addr_ready = 1'b1;
                        filter_data_ready = (dst >= 3);
                    end
                    default: begin
                        filter_addr_ready = 1'($urandom_range(0, 1));
                        filter_data_ready = 1'($urandom_range(0, 1));
                    end
                endcase
                if (inject && cyc == 3) begin
                    cfg_wr    = 1'b1;
                    cfg_idx   = 5'd5;
                    cfg_coeff = 16'h7777;
                    err_m     = 1'b1;
                end
                if (inject && cyc == 6) cfg_commit = 1'b1;
                if (filter_addr_valid && filter_addr_ready) a_dn = 1;
                if (filter_data_valid && filter_data_ready) d_dn = 1;
                else if (filter_data_valid) dst++;
                if (a_dn && d_dn) begin
                    e++;
                    a_dn = 0;
                    d_dn = 0;
                    dst  = 0;
                end
            end
            tick();
            cyc++;
            cfg_wr     = 1'b0;
            cfg_commit = 1'b0;
        end
        chk("upload_finished", 32'(fin), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_after", 32'(done), 32'd0);
        vs_i = 1'b0;
        filter_addr_ready = 1'b0;
        filter_data_ready = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        err_m = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        cfg_wr = 0; cfg_idx = 0; cfg_coeff = 0;
        cfg_commit = 0; cfg_abort = 0; err_clr = 0;
`ifdef FIR_PRESET_EN
        cfg_preset_load = 0; cfg_preset_sel = 0;
`endif
        vs_i = 0;
        filter_addr_ready = 0;
        filter_data_ready = 0;
        model_reset();
        repeat (2) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_valids", {30'd0, filter_addr_valid, filter_data_valid}, 32'd0);
        chk("rst_addr", filter_addr, 32'd0);
        chk("rst_data", filter_data, 32'd0);
        rst = 1'b1;
        tick();

        // identity kernel after reset
        commit();
        chk("busy_after_commit", 32'(busy), 32'd1);
        upload(0, 0, dc);
        chk("done_latency_identity", 32'(dc), 32'd25);

        // single negative write
        wr(0, -3);
        commit();
        upload(0, 0, dc);
        chk("done_latency_neg", 32'(dc), 32'd25);

        // data channel stalled, address channel free
        commit();
        upload(1, 0, dc);

        // out-of-range index, clear, set-beats-clear
        wr(30, 123);
        chk("err_bad_idx", 32'(err), 32'(err_m));
        clear_err();
        cfg_wr = 1'b1; cfg_idx = 5'd31; err_clr = 1'b1;
        tick();
        cfg_wr = 1'b0; err_clr = 1'b0;
        chk("err_set_wins", 32'(err), 32'd1);
        clear_err();

        // write and commit attempts during SEND
        commit();
        upload(0, 1, dc);
        chk("err_busy_write", 32'(err), 32'(err_m));
        clear_err();

        // abort before vsync
        commit();
        chk("busy_armed", 32'(busy), 32'd1);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("busy_abort", 32'(busy), 32'd0);
        vs_i = 1'b1;
        repeat (3) begin
            tick();
            chk("no_valid_abort",
                {30'd0, filter_addr_valid, filter_data_valid}, 32'd0);
        end
        vs_i = 1'b0;
        tick();

        // abort and vsync edge in the same cycle
        commit();
        cfg_abort = 1'b1;
        vs_i = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("busy_abort_vs", 32'(busy), 32'd0);
        tick();
        chk("no_valid_abort_vs",
            {30'd0, filter_addr_valid, filter_data_valid}, 32'd0);
        vs_i = 1'b0;
        tick();

        // write and commit in the same cycle
        cfg_wr = 1'b1; cfg_idx = 5'd7; cfg_coeff = 16'h8123;
        cfg_commit = 1'b1;
        tick();
        cfg_wr = 1'b0; cfg_commit = 1'b0;
        shadow_m[7] = -32477;
        upload(2, 0, dc);

        // randomized kernels and handshakes
        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 8; w++) begin
                wr(int'($urandom_range(0, 27)),
                   int'($urandom_range(0, 65535)) - 32768);
            end
            chk("err_random", 32'(err), 32'(err_m));
            commit();
            upload(2, 0, dc);
            if (err_m) clear_err();
        end

        // reset mid-upload restores identity
        commit();
        vs_i = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_valids",
            {30'd0, filter_addr_valid, filter_data_valid}, 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        tick();
        vs_i = 1'b0;
        rst = 1'b1;
        model_reset();
        tick();
        commit();
        upload(0, 0, dc);

`ifdef FIR_PRESET_EN
        // sharpen preset
        cfg_preset_load = 1'b1;
        cfg_preset_sel  = 2'd2;
        tick();
        cfg_preset_load = 1'b0;
        for (int i = 0; i < 25; i++) begin
            int rr;
            int cc;
            rr = i / 5;
            cc = i % 5;
            shadow_m[i] = 0;
            if (rr >= 1 && rr <= 3 && cc >= 1 && cc <= 3) shadow_m[i] = -256;
            if (i == 12) shadow_m[i] = 2304;
        end
        commit();
        upload(0, 0, dc);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_coeff_sequencer.md
# fir_coeff_sequencer

Frame-synchronous controller that loads the 5x5 FIR kernel into the filter's coefficient store. The host fills a 25-entry shadow register file, then commits. The block waits for the next vertical-sync rising edge and streams the kernel as 25 (address, data) pairs over the store's independent valid/ready address and data channels. This keeps kernel swaps out of active video and gives the host busy, done and error status.

## Interface
Parameters:
- COEFF_W, 16: coefficient width, signed Q8.8.
- NUM_TAPS, 25: kernel entries, row-major (index = 5*row + col).
- ADDR_STRIDE, 4: byte stride between entries on the address channel.

Ports:
- clk, in, 1: single clock for all logic; vs_i, cfg_* and store channels are synchronous to it.
- rst, in, 1: asynchronous, active-low reset.
- cfg_wr, in, 1: write cfg_coeff into shadow[cfg_idx].
- cfg_idx, in, 5: shadow index; values 0..24 are valid.
- cfg_coeff, in, 16: signed coefficient.
- cfg_commit, in, 1: one-cycle pulse; arms an upload.
- cfg_abort, in, 1: cancels an armed upload that has not started.
- err_clr, in, 1: clears err.
- vs_i, in, 1: vertical sync from the video timing.
- filter_addr, out, 32: byte address = index*ADDR_STRIDE.
- filter_addr_valid, out, 1: address-channel valid.
- filter_addr_ready, in, 1: address-channel ready.
- filter_data, out, 32: coefficient sign-extended to 32 bits.
- filter_data_valid, out, 1: data-channel valid.
- filter_data_ready, in, 1: data-channel ready.
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: one-cycle pulse when an upload completes.
- err, out, 1: sticky; set on a rejected write, rejected commit or out-of-range index.

## Operation
- States: IDLE, ARMED, SEND, FINISH.
- IDLE
  - cfg_wr with cfg_idx<25 updates the shadow.
  - cfg_idx>=25: the write is dropped and err is set.
  - cfg_commit moves to ARMED.
  - cfg_wr and cfg_commit in the same cycle: the write lands first, and the commit uploads the new value.
- ARMED
  - A vs_i rising edge (vs_i=1 while the registered previous value was 0) moves to SEND with idx=0.
  - cfg_abort returns to IDLE with no store traffic.
  - Abort and vs edge in the same cycle: abort wins.
- SEND
  - Both valids are asserted together for entry idx.
  - Each channel drops its valid independently after its own valid&ready handshake.
  - When both channels have completed for idx, idx advances and both valids re-assert the next cycle for the next entry.
  - Valid is never withdrawn before its handshake, and payload is stable while valid is high.
  - When entry 24 completes on both channels, move to FINISH.
- FINISH: done=1 for one cycle, then IDLE.
- Writes to the shadow: only accepted in IDLE. In ARMED, SEND or FINISH, cfg_wr is ignored and err is set.
- Commits: cfg_commit outside IDLE is ignored and sets err.
- cfg_abort in SEND or FINISH is ignored; an upload always completes all 25 entries.
- err_clr clears err. If a set event occurs in the same cycle, the set wins.

## Timing
- Reset values:
  - State IDLE, idx 0, all valids 0, done 0, busy 0, err 0.
  - filter_addr and filter_data are 0.
  - Shadow holds the identity kernel: shadow[12]=16'sd256, all others 0.
- Reset asserted mid-upload: valids drop asynchronously and the upload is lost. The shadow returns to identity.
- Latency:
  - Commit sampled at edge N: busy=1 from N+1.
  - vs_i rise sampled at edge K in ARMED: valids high from K+1.
- Throughput with both readies held high: one entry per cycle. Entry i is presented at K+1+i.
- done pulses at K+26, and busy falls at K+27.
- All outputs are registered. There is no combinational path from ready to valid.

## Configuration
- FIR_PRESET_EN
  - Defined: adds inputs cfg_preset_load (pulse) and cfg_preset_sel[1:0].
  - The presets are 0 identity, 1 box blur (all 10, ~1/25 in Q8.8), 2 sharpen (centre 2304, the 3x3 neighbours around centre -256, others 0) and 3 Gaussian 5x5 (integer weights scaled to sum 256).
  - In IDLE, a preset load copies the whole selected preset into the shadow in one cycle. Outside IDLE it is ignored and sets err.
  - cfg_preset_load together with cfg_wr in the same cycle: the preset wins.
  - Undefined: the ports are absent and the shadow is host-written only.

## Structure
- Package fir_cfg_pkg holds:
  - NUM_TAPS, COEFF_W, ADDR_STRIDE, IDENTITY_IDX=12, UNITY=256.
  - The state enum.
  - The preset coefficient constants.
- Sub-module fir_coeff_presets: a combinational preset ROM (sel in -> 25 coefficients out), instantiated only under FIR_PRESET_EN.
- The shadow register file, FSM, edge detect and channel trackers live in fir_coeff_sequencer.

## Test plan
- Reset: readback check, with readies high and vs_i pulsed, shows the upload carries identity: only entry 12 (addr 0x30) is 0x00000100; all other entries are 0.
- Write shadow[0]=-3, commit, vs_i rise at cycle K: addr 0x00 / data 0xFFFFFFFD at K+1; done at K+26.
- Data ready stalled 3 cycles per entry, address ready high: address valid drops after 1 cycle, data valid holds with stable payload, and idx advances only after both handshakes.
- cfg_wr during SEND and cfg_idx=30 in IDLE: shadow unchanged, err=1; after err_clr, err=0.
- Commit then cfg_abort before vs_i: no valid ever asserted, busy=0 the cycle after the abort.
- FIR_PRESET_EN: preset 2 load then upload gives entry 12 = 0x00000900 and entry 6 = 0xFFFFFF00.
